skrol_displej: RTL and testbench

- Downstream consumer of the character-pattern lookup: drives a multiplexed N-digit common-anode 7-segment display with a horizontally scrolling text window.
- Generates `char_index` for the lookup and receives the 8-bit pattern back combinationally in the same cycle.
- Registers the pattern, converted to pad polarity, together with the one-hot digit select.
- Sits between the character lookup and the board pins.

---
 rtl/skrol_displej.sv | 121 ++++++++++++
 tb/tb_skrol_displej.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/skrol_displej.sv
// skrol_displej: drives a multiplexed common-anode 7-segment display with a
// horizontally scrolling text window.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   en         in   scroll enable; 0 freezes the window, multiplexing runs on
//   char_index out  index into the character lookup, (offset + digit) mod WRAP
//   char_seg   in   active-high pattern returned by the lookup, {a..g, dp}
//   seg        out  registered segment drive, pad polarity
//   an         out  registered one-hot digit select, an[0] = leftmost digit
module skrol_displej #(
  parameter int N_DIGITS       = 4,
  parameter int TEXT_LEN       = 12,
  parameter int GAP            = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SCROLL_DIV     = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [4:0]          char_index,
  input  logic [7:0]          char_seg,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int WRAP  = TEXT_LEN + GAP;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SCR_W = $clog2(SCROLL_DIV);
  localparam int DIG_W = $clog2(N_DIGITS);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [4:0]       OFF_LAST = 5'(WRAP - 1);
  localparam logic [5:0]       WRAP_6   = 6'(WRAP);

  localparam logic [7:0]          SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{SEG_ACTIVE_LOW}};

  if (WRAP > 32 || WRAP < 1) begin : g_bad_wrap
    $error("skrol_displej: TEXT_LEN+GAP must lie in 1..32");
  end
  if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
    $error("skrol_displej: N_DIGITS must lie in 2..8");
  end
  if (REFRESH_DIV < 2 || SCROLL_DIV < 2) begin : g_bad_div
    $error("skrol_displej: REFRESH_DIV and SCROLL_DIV must be >= 2");
  end

  // Active-high logical value to pad polarity.
  function automatic logic [7:0] to_pad_seg(input logic [7:0] v);
    return v ^ SEG_OFF;
  endfunction

  function automatic logic [N_DIGITS-1:0] to_pad_an(input logic [N_DIGITS-1:0] v);
    return v ^ AN_OFF;
  endfunction

  logic [REF_W-1:0]    r_ref_cnt;
  logic [DIG_W-1:0]    r_digit;
  logic [SCR_W-1:0]    r_scr_cnt;
  logic [4:0]          r_offset;
  logic [7:0]          r_seg_p1;
  logic [N_DIGITS-1:0] r_an_p1;

  logic [5:0]          w_sum;
  logic [N_DIGITS-1:0] w_onehot;

  // Stage p0: refresh timing and digit selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_digit   <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt <= '0;
      r_digit   <= (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // Stage p0: scroll timing; with en low the partial count is kept, not cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scr_cnt <= '0;
      r_offset  <= '0;
    end else if (en) begin
      if (r_scr_cnt == SCR_LAST) begin
        r_scr_cnt <= '0;
        r_offset  <= (r_offset == OFF_LAST) ? '0 : r_offset + 5'd1;
      end else begin
        r_scr_cnt <= r_scr_cnt + SCR_W'(1);
      end
    end
  end

  // Lookup index depends only on registered state. The 6-bit sum cannot
  // overflow (offset <= 31, digit <= 7), and the modulo folds it into the window.
  assign w_sum      = 6'(r_offset) + 6'(r_digit);
  assign char_index = 5'(w_sum % WRAP_6);
  assign w_onehot   = N_DIGITS'(1) << r_digit;

  // Stage p1: pattern and digit select registered together so a digit never
  // shows its neighbour's pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p1 <= SEG_OFF;
      r_an_p1  <= AN_OFF;
    end else begin
      r_seg_p1 <= to_pad_seg(char_seg);
      r_an_p1  <= to_pad_an(w_onehot);
    end
  end

  assign seg = r_seg_p1;
  assign an  = r_an_p1;

endmodule

// File: tb/tb_skrol_displej.sv
// tb_skrol_displej: self-checking bench for skrol_displej.
// A cycle-count model (elapsed cycles and enabled cycles since reset, turned
// into digit/offset by division) predicts an, seg and char_index every cycle;
// directed literal checks pin the model at hand-computed points.
module tb_skrol_displej;

  localparam int N   = 4;
  localparam int TL  = 12;
  localparam int GP  = 4;
  localparam int RD  = 4;
  localparam int SD  = 64;
  localparam int WR  = TL + GP;

  logic         clk;
  logic         rst;
  logic         en;
  logic [4:0]   char_index;
  logic [7:0]   char_seg;
  logic [7:0]   seg;
  logic [N-1:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  skrol_displej #(
    .N_DIGITS(N), .TEXT_LEN(TL), .GAP(GP),
    .REFRESH_DIV(RD), .SCROLL_DIV(SD), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .char_index(char_index), .char_seg(char_seg),
    .seg(seg), .an(an)
  );

  function automatic logic [7:0] lut(input int idx);
    case (idx)
      0:         return 8'h6E;
      1:         return 8'h9E;
      2, 3, 10:  return 8'h1C;
      11:        return 8'h7B;
      default:   return 8'h00;
    endcase
  endfunction

  assign char_seg = lut(int'(char_index));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: position on screen follows purely from elapsed cycle counts.
  function automatic int digit_of(input int t);
    return (t / RD) % N;
  endfunction

  function automatic int idx_of(input int t, input int e);
    return ((e / SD) % WR + digit_of(t)) % WR;
  endfunction

  int       m_t = 0;
  int       m_e = 0;
  bit       m_valid = 1'b0;
  logic [3:0] m_an;
  logic [7:0] m_seg;

  always @(posedge clk) begin
    if (rst) begin
      m_t     <= 0;
      m_e     <= 0;
      m_valid <= 1'b1;
      m_an    <= 4'hF;
      m_seg   <= 8'hFF;
    end else if (m_valid) begin
      m_an  <= ~(4'b0001 << digit_of(m_t));
      m_seg <= ~lut(idx_of(m_t, m_e));
      m_t   <= m_t + 1;
      if (en) m_e <= m_e + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg), 32'(m_seg));
      check("model_idx", 32'(char_index), 32'(idx_of(m_t, m_e)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Walks one full multiplex frame starting at the edge that shows digit 0.
  task automatic scan_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] an_tab  [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      check({tag, "_an"}, 32'(an), 32'(an_tab[i]));
      check({tag, "_seg"}, 32'(seg), 32'(seg_tab[i]));
      tick(4);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;

    // Reset and first displayed digit
    tick(3);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h000000FF);
    rst = 1'b0;
    tick(1);
    check("rel_idx", 32'(char_index), 32'd0);

    // Multiplex with scrolling frozen
    scan_frame("mux", 8'h91, 8'h61, 8'hE3, 8'hE3);
    check("mux_off0", 32'(char_index), 32'd0);

    // Scroll to offset 15, then wrap back to 0
    en = 1'b1;
    tick(960);
    en = 1'b0;
    check("off15_idx", 32'(char_index), 32'd15);
    tick(1);
    check("off15_d0_an", 32'(an), 32'h0000000E);
    check("off15_d0_seg", 32'(seg), 32'h000000FF);
    tick(12);
    check("off15_d3_an", 32'(an), 32'h00000007);
    check("off15_d3_seg", 32'(seg), 32'h000000E3);
    en = 1'b1;
    tick(64);
    en = 1'b0;
    check("wrap_idx", 32'(char_index), 32'd3);

    // Offset 9: text end, dp and blank
    en = 1'b1;
    tick(576);
    en = 1'b0;
    tick(3);
    scan_frame("off9", 8'hFF, 8'hE3, 8'h84, 8'hFF);

    // Hold with a partial scroll count of 40
    en = 1'b1;
    tick(40);
    en = 1'b0;
    tick(100);
    check("hold_idx", 32'(char_index), 32'd12);
    en = 1'b1;
    tick(23);
    check("resume23_idx", 32'(char_index), 32'd10);
    tick(1);
    check("resume24_idx", 32'(char_index), 32'd11);

    // Scroll step landing on the same edge as a digit advance
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(63);
    check("coinc_pre_idx", 32'(char_index), 32'd11);
    tick(1);
    check("coinc_post_idx", 32'(char_index), 32'd13);

    // Reset mid-operation at offset 7, digit 2, ref_cnt 3
    tick(768);
    en = 1'b0;
    tick(3);
    check("mid_idx", 32'(char_index), 32'd9);
    rst = 1'b1;
    tick(1);
    check("mid_rst_an", 32'(an), 32'h0000000F);
    check("mid_rst_seg", 32'(seg), 32'h000000FF);
    check("mid_rst_idx", 32'(char_index), 32'd0);
    rst = 1'b0;
    tick(1);
    check("rerel_idx", 32'(char_index), 32'd0);
    scan_frame("remux", 8'h91, 8'h61, 8'hE3, 8'hE3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
